// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: owns the program counter, fetches each
// instruction over a valid handshake, holds it in IR and walks it through
// decode, register read, execute and write-back with one-hot phase strobes.
module instr_sequencer #(
    parameter int PC_W = 8,
    parameter int TMO  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            exec,
    input  logic            step,
    input  logic            halt_req,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd,
    input  logic            imem_valid,
    input  logic [15:0]     imem_data,
    output logic [15:0]     ir,
    output logic            rd_stb,
    output logic            ex_stb,
    output logic            wb_stb,
    output logic            busy,
    output logic            halted,
    output logic            err,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     icount
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_READ   = 3'd4;
    localparam logic [2:0] S_EXEC   = 3'd5;
    localparam logic [2:0] S_WB     = 3'd6;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [15:0] HALT_WORD = 16'hFFFF;
    localparam logic [3:0]  JUMP_OP   = 4'hE;

    // The wait counter only needs to reach TMO-1: the last empty WAIT cycle
    // is recognised by value rather than by counting one past it.
    localparam int               CNT_W    = (TMO < 2) ? 1 : $clog2(TMO);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO - 1);

    logic [2:0]      state_q,    state_d;
    logic [PC_W-1:0] pc_q,       pc_d;
    logic [15:0]     ir_q,       ir_d;
    logic [15:0]     icount_q,   icount_d;
    logic            run_mode_q, run_mode_d;
    logic            err_q,      err_d;
    logic [CNT_W-1:0] wcnt_q,    wcnt_d;

    logic [15:0] icount_inc;
    logic        keep_running;

    // Retirement count saturates instead of wrapping.
    assign icount_inc   = (icount_q == 16'hFFFF) ? icount_q : icount_q + 16'd1;
    // After a retirement, continue only in free-run with no stop request.
    assign keep_running = run_mode_q && !halt_req;

    // Next-state, PC, IR and status computation.
    always_comb begin
        // NOTE: every _d takes its hold value first so no branch can leave it
        // unassigned and infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        icount_d   = icount_q;
        run_mode_d = run_mode_q;
        err_d      = err_q;
        wcnt_d     = wcnt_q;

        case (state_q)
            S_IDLE: begin
                if (exec) begin
                    state_d    = S_FETCH;
                    run_mode_d = 1'b1;
                end else if (step) begin
                    state_d    = S_FETCH;
                    run_mode_d = 1'b0;
                end
            end
            S_FETCH: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_valid) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end else if (wcnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (ir_q == HALT_WORD) begin
                    state_d = S_HALT;
                end else if (ir_q[15:12] == JUMP_OP) begin
                    pc_d     = ir_q[PC_W-1:0];
                    icount_d = icount_inc;
                    state_d  = keep_running ? S_FETCH : S_IDLE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            S_WB: begin
                pc_d     = pc_q + 1'b1;
                icount_d = icount_inc;
                state_d  = keep_running ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                if (exec) begin
                    pc_d       = '0;
                    err_d      = 1'b0;
                    run_mode_d = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            icount_q   <= '0;
            run_mode_q <= 1'b0;
            err_q      <= 1'b0;
            wcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            icount_q   <= icount_d;
            run_mode_q <= run_mode_d;
            err_q      <= err_d;
            wcnt_q     <= wcnt_d;
        end
    end

    // Outputs decode only registered state, so no input reaches an output
    // combinationally and at most one strobe can be high.
    assign imem_addr = pc_q;
    assign imem_rd   = (state_q == S_FETCH);
    assign rd_stb    = (state_q == S_READ);
    assign ex_stb    = (state_q == S_EXEC);
    assign wb_stb    = (state_q == S_WB);
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted    = (state_q == S_HALT);
    assign err       = err_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign icount    = icount_q;

endmodule
